// File: rtl/gpio_pin_arbiter.sv
// Round-robin owner arbitration for a shared GPIO pin bus, with minimum hold and a one-cycle gap.
// Optional owner preemption after MAX_HOLD cycles is built when GPIO_PIN_ARB_TIMEOUT_EN is defined.
module gpio_pin_arbiter #(
  parameter int unsigned      NUM_REQ    = 4,
  parameter int unsigned      WIDTH      = 8,
  parameter int unsigned      MIN_HOLD   = 4,
  parameter logic [WIDTH-1:0] IDLE_VALUE = '0,
  parameter int unsigned      MAX_HOLD   = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]         gpio_pin,
  output logic                     busy
);

  localparam int unsigned     IdxW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned     HoldW   = $clog2(MIN_HOLD + 1);
  localparam logic [IdxW-1:0] PtrRst  = IdxW'(NUM_REQ - 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(MIN_HOLD);

  typedef enum logic [1:0] {StIdle, StOwn, StGap} state_e;

  state_e             r_state, w_state_d;
  logic [IdxW-1:0]    r_owner, w_owner_d;
  logic [IdxW-1:0]    r_rr_ptr, w_rr_ptr_d;
  logic [HoldW-1:0]   r_hold_cnt, w_hold_cnt_d;
  logic [NUM_REQ-1:0] r_gnt, w_gnt_d;
  logic [WIDTH-1:0]   r_pin, w_pin_d;

  logic [WIDTH-1:0]   w_data [NUM_REQ];
  logic               w_win_valid;
  logic [IdxW-1:0]    w_win_idx;
  logic [IdxW-1:0]    w_cand;
  logic               w_preempt;

  for (genvar g = 0; g < NUM_REQ; g++) begin : gen_unpack
    assign w_data[g] = req_data[g*WIDTH +: WIDTH];
  end

  // First set request strictly after the pointer, wrapping; the pointer itself is checked last.
  always_comb begin
    w_win_valid = 1'b0;
    w_win_idx   = '0;
    w_cand      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_cand = IdxW'((32'(r_rr_ptr) + k) % NUM_REQ);
      if (!w_win_valid && req[w_cand]) begin
        w_win_valid = 1'b1;
        w_win_idx   = w_cand;
      end
    end
  end

`ifdef GPIO_PIN_ARB_TIMEOUT_EN
  localparam int unsigned      GrantW   = $clog2(MAX_HOLD + 1);
  localparam logic [GrantW-1:0] GrantMax = GrantW'(MAX_HOLD);

  logic [GrantW-1:0] r_grant_cnt, w_grant_cnt_d;
  logic              w_others;

  // r_gnt is the owner's one-hot while in StOwn, so this masks the owner out.
  assign w_others  = |(req & ~r_gnt);
  assign w_preempt = (r_state == StOwn) && (r_grant_cnt >= GrantMax) && w_others;

  always_comb begin
    w_grant_cnt_d = '0;
    if (w_state_d == StOwn) begin
      if (r_state != StOwn) begin
        w_grant_cnt_d = GrantW'(1);
      end else if (r_grant_cnt < GrantMax) begin
        w_grant_cnt_d = r_grant_cnt + GrantW'(1);
      end else begin
        w_grant_cnt_d = r_grant_cnt;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_grant_cnt <= '0;
    end else begin
      r_grant_cnt <= w_grant_cnt_d;
    end
  end
`else
  assign w_preempt = 1'b0;
`endif

  always_comb begin
    w_state_d    = r_state;
    w_owner_d    = r_owner;
    w_rr_ptr_d   = r_rr_ptr;
    w_hold_cnt_d = r_hold_cnt;
    w_gnt_d      = r_gnt;
    w_pin_d      = r_pin;
    unique case (r_state)
      StIdle, StGap: begin
        if (w_win_valid) begin
          w_state_d    = StOwn;
          w_owner_d    = w_win_idx;
          w_rr_ptr_d   = w_win_idx;
          w_hold_cnt_d = HoldW'(1);
          w_gnt_d      = NUM_REQ'(1) << w_win_idx;
          w_pin_d      = w_data[w_win_idx];
        end else begin
          w_state_d    = StIdle;
          w_hold_cnt_d = '0;
          w_gnt_d      = '0;
          w_pin_d      = IDLE_VALUE;
        end
      end
      StOwn: begin
        if (w_preempt || (!req[r_owner] && (r_hold_cnt >= HoldMax))) begin
          w_state_d    = StGap;
          w_hold_cnt_d = '0;
          w_gnt_d      = '0;
          w_pin_d      = IDLE_VALUE;
        end else begin
          // A dropped request inside the hold window keeps the last pin value.
          if (req[r_owner]) begin
            w_pin_d = w_data[r_owner];
          end
          if (r_hold_cnt < HoldMax) begin
            w_hold_cnt_d = r_hold_cnt + HoldW'(1);
          end
        end
      end
      default: begin
        w_state_d = StIdle;
        w_gnt_d   = '0;
        w_pin_d   = IDLE_VALUE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_owner    <= '0;
      r_rr_ptr   <= PtrRst;
      r_hold_cnt <= '0;
      r_gnt      <= '0;
      r_pin      <= IDLE_VALUE;
    end else begin
      r_state    <= w_state_d;
      r_owner    <= w_owner_d;
      r_rr_ptr   <= w_rr_ptr_d;
      r_hold_cnt <= w_hold_cnt_d;
      r_gnt      <= w_gnt_d;
      r_pin      <= w_pin_d;
    end
  end

  assign gnt      = r_gnt;
  assign gpio_pin = r_pin;
  assign busy     = (r_state != StIdle);

endmodule
